// File: rtl/cheat_engine_v2.sv
`default_nettype none
// ============================================================================
// Module      : cheat_engine_v2
// Description : Cheat-code override engine. Code slots are loaded as 4-word
//               records over a 32-bit valid/ready stream. CPU read cycles are
//               matched against the slots. The lowest-index hit returns a
//               registered replacement value.
// Revision    : 1.0 - initial release
// ============================================================================
module cheat_engine_v2 #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_CODES  = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               clear_req,
    input  logic                               wr_valid,
    input  logic [31:0]                        wr_data,
    output logic                               wr_ready,
    input  logic                               bus_strobe,
    input  logic [ADDR_WIDTH-1:0]              bus_addr,
    input  logic [DATA_WIDTH-1:0]              bus_data,
    output logic                               ovr,
    output logic [DATA_WIDTH-1:0]              ovr_data,
    output logic [$clog2(MAX_CODES+1)-1:0]     count,
    output logic                               overflow,
    output logic                               busy
);

    localparam int CW = $clog2(MAX_CODES + 1);
    localparam int IW = $clog2(MAX_CODES);
    localparam logic [IW-1:0] c_last_idx = IW'(MAX_CODES - 1);
    localparam logic [CW-1:0] c_max_cnt  = CW'(MAX_CODES);

    typedef enum logic [2:0] {
        W_FLAGS = 3'd0,
        W_ADDR  = 3'd1,
        W_COMP  = 3'd2,
        W_REPL  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    // Slot storage
    logic [MAX_CODES-1:0]  r_valid;
    logic [MAX_CODES-1:0]  r_cmp_en;
    logic [MAX_CODES-1:0]  r_inv;
    logic [MAX_CODES-1:0]  r_oneshot;
    logic [ADDR_WIDTH-1:0] r_addr [MAX_CODES];
    logic [DATA_WIDTH-1:0] r_comp [MAX_CODES];
    logic [DATA_WIDTH-1:0] r_repl [MAX_CODES];

    // Staging for the code currently being received
    logic [2:0]            r_stg_flags;
    logic [ADDR_WIDTH-1:0] r_stg_addr;
    logic [DATA_WIDTH-1:0] r_stg_comp;

    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic [IW-1:0]         r_clr_idx;
    logic                  r_ovr;
    logic [DATA_WIDTH-1:0] r_ovr_data;

    logic                  w_hs;
    logic                  w_repl_hs;
    logic                  w_store;
    logic                  w_full_drop;
    logic [MAX_CODES-1:0]  w_hit;
    logic                  w_any;
    logic [IW-1:0]         w_win;

    // Ready is withheld while reset is asserted and during the clear sweep
    assign wr_ready    = (r_state != S_CLEAR) && !reset;
    assign w_hs        = wr_valid && wr_ready;
    // A clear request on the final word aborts the code as well
    assign w_repl_hs   = w_hs && (r_state == W_REPL) && !clear_req;
    assign w_store     = w_repl_hs && (r_count < c_max_cnt);
    assign w_full_drop = w_repl_hs && (r_count >= c_max_cnt);

    assign busy     = (r_state == S_CLEAR);
    assign count    = r_count;
    assign overflow = r_overflow;
    assign ovr      = r_ovr;
    assign ovr_data = r_ovr_data;

    // Per-slot hit detection
    for (genvar gi = 0; gi < MAX_CODES; gi++) begin : g_slot
        assign w_hit[gi] = r_valid[gi] && enable && bus_strobe &&
                           (r_addr[gi] == bus_addr) &&
                           (!r_cmp_en[gi] ||
                            ((r_comp[gi] == bus_data) ^ r_inv[gi]));
    end

    // Lowest-index hit wins: scan downward so the last assignment is the lowest
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = MAX_CODES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any = 1'b1;
                w_win = IW'(i);
            end
        end
    end

    // Loader / clear state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= W_FLAGS;
        else       r_state <= w_state_nxt;
    end

    // Next-state: advance on handshake, clear request preempts any partial code
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_idx == c_last_idx) w_state_nxt = W_FLAGS;
            W_FLAGS: if (clear_req) w_state_nxt = S_CLEAR;
                     else if (w_hs) w_state_nxt = W_ADDR;
            W_ADDR:  if (clear_req) w_state_nxt = S_CLEAR;
                     else if (w_hs) w_state_nxt = W_COMP;
            W_COMP:  if (clear_req) w_state_nxt = S_CLEAR;
                     else if (w_hs) w_state_nxt = W_REPL;
            W_REPL:  if (clear_req) w_state_nxt = S_CLEAR;
                     else if (w_hs) w_state_nxt = W_FLAGS;
            default: w_state_nxt = W_FLAGS;
        endcase
    end

    // Capture the first three words of a code as they are accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stg_flags <= '0;
            r_stg_addr  <= '0;
            r_stg_comp  <= '0;
        end else if (w_hs) begin
            if (r_state == W_FLAGS) r_stg_flags <= wr_data[2:0];
            if (r_state == W_ADDR)  r_stg_addr  <= wr_data[ADDR_WIDTH-1:0];
            if (r_state == W_COMP)  r_stg_comp  <= wr_data[DATA_WIDTH-1:0];
        end
    end

    // Slot count, sticky overflow and clear sweep index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_clr_idx  <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
            if (r_clr_idx == c_last_idx) begin
                r_count    <= '0;
                r_overflow <= 1'b0;
            end
        end else begin
            r_clr_idx <= '0;
            if (w_store)     r_count    <= r_count + 1'b1;
            if (w_full_drop) r_overflow <= 1'b1;
        end
    end

    // Slot payload; only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_CODES; i++) begin
            if (w_store && (r_count == CW'(i))) begin
                r_cmp_en[i]  <= r_stg_flags[0];
                r_inv[i]     <= r_stg_flags[1];
                r_oneshot[i] <= r_stg_flags[2];
                r_addr[i]    <= r_stg_addr;
                r_comp[i]    <= r_stg_comp;
                r_repl[i]    <= wr_data[DATA_WIDTH-1:0];
            end
        end
    end

    // Valid bits: set on store, cleared by sweep or by consuming a one-shot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < MAX_CODES; i++) begin
                if (w_store && (r_count == CW'(i))) r_valid[i] <= 1'b1;
            end
            if (r_state == S_CLEAR)         r_valid[r_clr_idx] <= 1'b0;
            if (w_any && r_oneshot[w_win])  r_valid[w_win]     <= 1'b0;
        end
    end

    // Registered override result; zero when nothing hit this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovr      <= 1'b0;
            r_ovr_data <= '0;
        end else begin
            r_ovr      <= w_any;
            r_ovr_data <= w_any ? r_repl[w_win] : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cheat_engine_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_cheat_engine_v2
// Description : Directed self-checking bench for cheat_engine_v2 (4 slots).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cheat_engine_v2;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_CODES  = 4;
    localparam int CW         = $clog2(MAX_CODES + 1);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic                  clear_req;
    logic                  wr_valid;
    logic [31:0]           wr_data;
    logic                  wr_ready;
    logic                  bus_strobe;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_data;
    logic                  ovr;
    logic [DATA_WIDTH-1:0] ovr_data;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit r_gaps  = 1'b0;

    cheat_engine_v2 #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_CODES (MAX_CODES)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear_req (clear_req),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .bus_strobe(bus_strobe),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .ovr       (ovr),
        .ovr_data  (ovr_data),
        .count     (count),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and wait (bounded) for the handshake
    task automatic send_word(input logic [31:0] w);
        bit taken;
        int n;
        if (r_gaps) begin
            wr_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        wr_valid = 1'b1;
        wr_data  = w;
        taken    = 1'b0;
        n        = 0;
        while (!taken && n < 50) begin
            @(negedge clk);
            taken = wr_ready;
            tick();
            n++;
        end
        wr_valid = 1'b0;
        if (!taken) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_word timeout: got no ready expected ready");
        end
    endtask

    task automatic load_code(input logic [31:0] f, input logic [31:0] a,
                             input logic [31:0] c, input logic [31:0] r);
        send_word(f);
        send_word(a);
        send_word(c);
        send_word(r);
    endtask

    // One-cycle read strobe; the registered override is visible after the edge
    task automatic strobe(input logic [15:0] a, input logic [7:0] d);
        bus_strobe = 1'b1;
        bus_addr   = a;
        bus_data   = d;
        tick();
        bus_strobe = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("clear_done", 32'(busy), 32'd0);
    endtask

    int nbusy;

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        clear_req  = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        bus_strobe = 1'b0;
        bus_addr   = '0;
        bus_data   = '0;
        tick();
        tick();
        chk("rst_ovr",      32'(ovr),      32'd0);
        chk("rst_ovr_data", 32'(ovr_data), 32'd0);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(wr_ready), 32'd1);

        // Unconditional code, then enable gating
        load_code(32'h0, 32'h8123, 32'h0, 32'hEA);
        chk("count1", 32'(count), 32'd1);
        strobe(16'h8123, 8'h55);
        chk("plain_ovr",  32'(ovr),      32'd1);
        chk("plain_data", 32'(ovr_data), 32'hEA);
        tick();
        chk("idle_ovr", 32'(ovr), 32'd0);
        enable = 1'b0;
        strobe(16'h8123, 8'h55);
        chk("dis_ovr",  32'(ovr),      32'd0);
        chk("dis_data", 32'(ovr_data), 32'd0);
        enable = 1'b1;

        // Compare and compare-invert codes
        load_code(32'h1, 32'h9000, 32'h42, 32'h00);
        strobe(16'h9000, 8'h42);
        chk("cmp_eq_ovr",  32'(ovr),      32'd1);
        chk("cmp_eq_data", 32'(ovr_data), 32'h00);
        strobe(16'h9000, 8'h43);
        chk("cmp_ne_ovr", 32'(ovr), 32'd0);
        load_code(32'h3, 32'h9100, 32'h42, 32'h77);
        strobe(16'h9100, 8'h42);
        chk("inv_eq_ovr", 32'(ovr), 32'd0);
        strobe(16'h9100, 8'h43);
        chk("inv_ne_ovr",  32'(ovr),      32'd1);
        chk("inv_ne_data", 32'(ovr_data), 32'h77);
        chk("count3", 32'(count), 32'd3);

        // Duplicate address in a higher slot loses; fifth code overflows
        load_code(32'h0, 32'h8123, 32'h0, 32'h99);
        strobe(16'h8123, 8'h00);
        chk("prio_data", 32'(ovr_data), 32'hEA);
        load_code(32'h0, 32'hC000, 32'h0, 32'h33);
        chk("full_count", 32'(count),    32'd4);
        chk("overflow",   32'(overflow), 32'd1);
        strobe(16'hC000, 8'h00);
        chk("ovf_nomatch", 32'(ovr), 32'd0);

        // Clear sweep length and aftermath
        pulse_clear();
        chk("clr_ready", 32'(wr_ready), 32'd0);
        nbusy = 0;
        while (busy && nbusy < 100) begin
            nbusy++;
            tick();
        end
        chk("busy_cycles",   32'(nbusy),    32'(MAX_CODES));
        chk("clr_count",     32'(count),    32'd0);
        chk("clr_overflow",  32'(overflow), 32'd0);
        strobe(16'h8123, 8'h55);
        chk("clr_nomatch", 32'(ovr), 32'd0);

        // Priority between same-address slots, then one-shot consumption
        load_code(32'h0, 32'hA000, 32'h0, 32'h11);
        load_code(32'h0, 32'hA000, 32'h0, 32'h22);
        strobe(16'hA000, 8'h00);
        chk("prio_low", 32'(ovr_data), 32'h11);
        load_code(32'h4, 32'hB000, 32'h0, 32'h5A);
        strobe(16'hB000, 8'h00);
        chk("oneshot1_ovr",  32'(ovr),      32'd1);
        chk("oneshot1_data", 32'(ovr_data), 32'h5A);
        strobe(16'hB000, 8'h00);
        chk("oneshot2_ovr", 32'(ovr), 32'd0);
        chk("oneshot_count", 32'(count), 32'd3);

        // Partial code aborted by a clear
        send_word(32'h0);
        send_word(32'hD000);
        pulse_clear();
        chk("abort_busy",  32'(busy),     32'd1);
        chk("abort_ready", 32'(wr_ready), 32'd0);
        wait_not_busy();
        load_code(32'h0, 32'hE000, 32'h0, 32'h66);
        chk("abort_count", 32'(count), 32'd1);
        strobe(16'hE000, 8'h00);
        chk("abort_ovr",  32'(ovr),      32'd1);
        chk("abort_data", 32'(ovr_data), 32'h66);

        // Stalls between words
        r_gaps = 1'b1;
        load_code(32'h0, 32'hF000, 32'h0, 32'h12);
        load_code(32'h1, 32'hF100, 32'h0C, 32'h34);
        r_gaps = 1'b0;
        chk("gap_count", 32'(count), 32'd3);
        strobe(16'hF000, 8'h00);
        chk("gap_data0", 32'(ovr_data), 32'h12);
        strobe(16'hF100, 8'h0C);
        chk("gap_data1", 32'(ovr_data), 32'h34);

        // Reset in the middle of a code
        send_word(32'h0);
        send_word(32'h1234);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_count", 32'(count), 32'd0);
        strobe(16'hF000, 8'h00);
        chk("mid_rst_nomatch", 32'(ovr), 32'd0);
        load_code(32'h0, 32'h1234, 32'h0, 32'hAB);
        chk("post_rst_count", 32'(count), 32'd1);
        strobe(16'h1234, 8'h00);
        chk("post_rst_data", 32'(ovr_data), 32'hAB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
